// File: rtl/video_pcie_line_sched.sv
// Packet scheduler: two 128-bit video line FIFOs -> PCIe DMA CPU read port.
// Optional statistics counters are enabled by defining VIDEO_PCIE_SCHED_STATS_EN.
module video_pcie_line_sched #(
  parameter int          LINE_BEATS = 160,
  parameter int          LEVEL_W    = 10,
  parameter logic [15:0] SYNC_FS    = 16'hA55A,
  parameter logic [15:0] SYNC_LN    = 16'hC33C,
  parameter logic [15:0] IDLE_WORD  = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_rd_en,
  output logic [127:0]       cpu_rd_data,
  input  logic [LEVEL_W-1:0] ch0_level,
  output logic               ch0_rd_en,
  input  logic [127:0]       ch0_rd_data,
  input  logic               ch0_fs,
  input  logic [LEVEL_W-1:0] ch1_level,
  output logic               ch1_rd_en,
  input  logic [127:0]       ch1_rd_data,
  input  logic               ch1_fs,
  output logic               pkt_ch,
  output logic               pkt_active
`ifdef VIDEO_PCIE_SCHED_STATS_EN
  ,
  output logic [31:0]        stat_idle_pkts,
  output logic [31:0]        stat_ch0_pkts,
  output logic [31:0]        stat_ch1_pkts
`endif
);

  localparam int BEAT_W = $clog2(LINE_BEATS + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS);
  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [1:0]        state_q, state_d;
  logic              pkt_ch_q, pkt_ch_d;
  logic              last_grant_q, last_grant_d;
  logic [1:0]        fs_pend_q, fs_pend_d;
  logic [1:0][15:0]  line_cnt_q, line_cnt_d;
  logic [127:0]      hdr_q, hdr_d;
  logic              hdr_flag_q, data_flag_q, data_ch_q, fill_flag_q;
  logic [127:0]      hold_q;

  logic              elig0_s, elig1_s, grant_valid_s, grant_ch_s, hdr_take_s;
  logic [15:0]       sync_word_s;

  // Arbitration: eligibility is only acted upon at the header beat.
  always_comb begin
    elig0_s       = (ch0_level >= LEVEL_W'(LINE_BEATS));
    elig1_s       = (ch1_level >= LEVEL_W'(LINE_BEATS));
    grant_valid_s = elig0_s | elig1_s;
    if (elig0_s && elig1_s) begin
      grant_ch_s = ~last_grant_q;
    end else begin
      grant_ch_s = elig1_s;
    end
    hdr_take_s  = cpu_rd_en && (state_q == ST_HDR);
    sync_word_s = fs_pend_q[grant_ch_s] ? SYNC_FS : SYNC_LN;
  end

  // Packet sequencing: beat counter and HDR/DATA/FILL state.
  always_comb begin
    beat_d       = beat_q;
    state_d      = state_q;
    pkt_ch_d     = pkt_ch_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_HDR: begin
        if (cpu_rd_en) begin
          beat_d = BEAT_W'(1);
          if (grant_valid_s) begin
            state_d      = ST_DATA;
            pkt_ch_d     = grant_ch_s;
            last_grant_d = grant_ch_s;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      ST_DATA, ST_FILL: begin
        if (cpu_rd_en) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_HDR;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        beat_d  = '0;
        state_d = ST_HDR;
      end
    endcase
  end

  // Header word, frame-start pending flags and per-channel line counters.
  always_comb begin
    hdr_d      = hdr_q;
    fs_pend_d  = fs_pend_q;
    line_cnt_d = line_cnt_q;
    if (hdr_take_s) begin
      if (grant_valid_s) begin
        hdr_d = {{6{sync_word_s}}, 15'd0, grant_ch_s, line_cnt_q[grant_ch_s]};
        fs_pend_d[grant_ch_s]  = 1'b0;
        line_cnt_d[grant_ch_s] = fs_pend_q[grant_ch_s] ? 16'd1
                                                       : line_cnt_q[grant_ch_s] + 16'd1;
      end else begin
        hdr_d = {8{IDLE_WORD}};
      end
    end else begin
      hdr_d = hdr_q;
    end
    // A frame start arriving with the clearing header must not be lost.
    if (ch0_fs) begin
      fs_pend_d[0] = 1'b1;
    end else begin
      fs_pend_d[0] = fs_pend_d[0];
    end
    if (ch1_fs) begin
      fs_pend_d[1] = 1'b1;
    end else begin
      fs_pend_d[1] = fs_pend_d[1];
    end
  end

  // FIFO read strobes follow the consumer directly so reads stay 1:1 with beats.
  always_comb begin
    ch0_rd_en = cpu_rd_en && (state_q == ST_DATA) && !pkt_ch_q;
    ch1_rd_en = cpu_rd_en && (state_q == ST_DATA) &&  pkt_ch_q;
  end

  // Output data mux driven by the one-cycle-delayed beat flags.
  always_comb begin
    if (hdr_flag_q) begin
      cpu_rd_data = hdr_q;
    end else if (data_flag_q) begin
      cpu_rd_data = data_ch_q ? ch1_rd_data : ch0_rd_data;
    end else if (fill_flag_q) begin
      cpu_rd_data = {8{IDLE_WORD}};
    end else begin
      cpu_rd_data = hold_q;
    end
  end

  assign pkt_ch     = pkt_ch_q;
  assign pkt_active = (state_q == ST_DATA);

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q       <= '0;
      state_q      <= ST_HDR;
      pkt_ch_q     <= 1'b0;
      last_grant_q <= 1'b1;
      fs_pend_q    <= 2'b00;
      line_cnt_q   <= '0;
      hdr_q        <= '0;
      hdr_flag_q   <= 1'b0;
      data_flag_q  <= 1'b0;
      data_ch_q    <= 1'b0;
      fill_flag_q  <= 1'b0;
      hold_q       <= '0;
    end else begin
      beat_q       <= beat_d;
      state_q      <= state_d;
      pkt_ch_q     <= pkt_ch_d;
      last_grant_q <= last_grant_d;
      fs_pend_q    <= fs_pend_d;
      line_cnt_q   <= line_cnt_d;
      hdr_q        <= hdr_d;
      hdr_flag_q   <= hdr_take_s;
      data_flag_q  <= cpu_rd_en && (state_q == ST_DATA);
      data_ch_q    <= pkt_ch_q;
      fill_flag_q  <= cpu_rd_en && (state_q == ST_FILL);
      hold_q       <= cpu_rd_data;
    end
  end

`ifdef VIDEO_PCIE_SCHED_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stat_idle_q, stat_ch0_q, stat_ch1_q;

  // Per-decision packet counters, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_idle_q <= 32'd0;
      stat_ch0_q  <= 32'd0;
      stat_ch1_q  <= 32'd0;
    end else if (hdr_take_s) begin
      if (!grant_valid_s) begin
        stat_idle_q <= sat_inc(stat_idle_q);
      end else if (grant_ch_s) begin
        stat_ch1_q <= sat_inc(stat_ch1_q);
      end else begin
        stat_ch0_q <= sat_inc(stat_ch0_q);
      end
    end else begin
      stat_idle_q <= stat_idle_q;
    end
  end

  assign stat_idle_pkts = stat_idle_q;
  assign stat_ch0_pkts  = stat_ch0_q;
  assign stat_ch1_pkts  = stat_ch1_q;
`endif

endmodule

// File: tb/tb_video_pcie_line_sched.sv
// Scoreboard bench for video_pcie_line_sched: an arbitration/header model pushes
// expected beats to a queue; each consumed beat is popped and compared.
module tb_video_pcie_line_sched;
  localparam int LB = 160;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_rd_en = 1'b0;
  logic [127:0] cpu_rd_data;
  logic [9:0]   ch0_level = 10'd0, ch1_level = 10'd0;
  logic         ch0_rd_en, ch1_rd_en;
  logic [127:0] ch0_rd_data = 128'd0, ch1_rd_data = 128'd0;
  logic         ch0_fs = 1'b0, ch1_fs = 1'b0;
  logic         pkt_ch, pkt_active;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] exp_q[$];
  logic [127:0] last_exp = 128'd0;

  logic        last_m;
  logic [15:0] cnt_m [2];
  logic        pend_m [2];
  int          exp_seq [2] = '{0, 0};
  int          fifo_seq [2] = '{0, 0};
  int          rd_cnt [2] = '{0, 0};

  video_pcie_line_sched dut (
    .clk(clk), .rst_n(rst_n), .cpu_rd_en(cpu_rd_en), .cpu_rd_data(cpu_rd_data),
    .ch0_level(ch0_level), .ch0_rd_en(ch0_rd_en), .ch0_rd_data(ch0_rd_data), .ch0_fs(ch0_fs),
    .ch1_level(ch1_level), .ch1_rd_en(ch1_rd_en), .ch1_rd_data(ch1_rd_data), .ch1_fs(ch1_fs),
    .pkt_ch(pkt_ch), .pkt_active(pkt_active)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] fifo_word(input int ch, input int seq);
    return {32'hDA7A_0000 | 32'(ch), 32'(seq), ~32'(seq), 32'(seq) ^ 32'h5A5A_5A5A};
  endfunction

  // FIFO models with one-cycle read latency
  always @(posedge clk) begin
    if (ch0_rd_en) begin
      ch0_rd_data <= fifo_word(0, fifo_seq[0]);
      fifo_seq[0] <= fifo_seq[0] + 1;
      rd_cnt[0]   <= rd_cnt[0] + 1;
    end
    if (ch1_rd_en) begin
      ch1_rd_data <= fifo_word(1, fifo_seq[1]);
      fifo_seq[1] <= fifo_seq[1] + 1;
      rd_cnt[1]   <= rd_cnt[1] + 1;
    end
  end

  task automatic model_reset();
    last_m    = 1'b1;
    cnt_m[0]  = 16'd0;
    cnt_m[1]  = 16'd0;
    pend_m[0] = 1'b0;
    pend_m[1] = 1'b0;
    exp_q.delete();
    last_exp  = 128'd0;
  endtask

  // One packet: header + n_data beats, optional random gaps, optional ch1_fs at header.
  task automatic send_packet(input int gap_pct, input bit fs1_hdr, input int n_data, input string tag);
    bit           e0, e1, valid, g;
    logic [15:0]  sync;
    logic [127:0] hdr, w;
    int           r0, r1, exp0, exp1;
    e0 = (ch0_level >= 10'(LB));
    e1 = (ch1_level >= 10'(LB));
    valid = e0 | e1;
    g = (e0 && e1) ? ~last_m : e1;
    if (valid) begin
      sync = pend_m[g] ? 16'hA55A : 16'hC33C;
      hdr  = {{6{sync}}, 15'd0, g, cnt_m[g]};
      cnt_m[g]  = pend_m[g] ? 16'd1 : cnt_m[g] + 16'd1;
      pend_m[g] = 1'b0;
      last_m    = g;
    end else begin
      hdr = {8{16'hFFFF}};
    end
    if (fs1_hdr) pend_m[1] = 1'b1;
    r0 = rd_cnt[0];
    r1 = rd_cnt[1];

    @(negedge clk);
    cpu_rd_en = 1'b1;
    ch1_fs    = fs1_hdr;
    exp_q.push_back(hdr);
    @(posedge clk); #1;
    ch1_fs = 1'b0;
    w = exp_q.pop_front();
    n_checks++;
    if (cpu_rd_data !== w)
      $display("FAIL %s header: got %h expected %h", tag, cpu_rd_data, w);
    if (cpu_rd_data !== w) n_fail++;
    last_exp = w;
    n_checks++;
    if (pkt_active !== valid || (valid && pkt_ch !== g)) begin
      $display("FAIL %s pkt_state: got active=%b ch=%b expected active=%b ch=%b", tag, pkt_active, pkt_ch, valid, g);
      n_fail++;
    end

    for (int i = 1; i <= n_data; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        @(negedge clk);
        cpu_rd_en = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (cpu_rd_data !== last_exp) begin
          $display("FAIL %s gap_hold beat %0d: got %h expected %h", tag, i, cpu_rd_data, last_exp);
          n_fail++;
        end
      end
      if (valid) begin
        exp_q.push_back(fifo_word(g, exp_seq[g]));
        exp_seq[g]++;
      end else begin
        exp_q.push_back({8{16'hFFFF}});
      end
      @(negedge clk);
      cpu_rd_en = 1'b1;
      @(posedge clk); #1;
      w = exp_q.pop_front();
      n_checks++;
      if (cpu_rd_data !== w) begin
        $display("FAIL %s data beat %0d: got %h expected %h", tag, i, cpu_rd_data, w);
        n_fail++;
      end
      last_exp = w;
    end
    @(negedge clk);
    cpu_rd_en = 1'b0;
    exp0 = (valid && !g) ? n_data : 0;
    exp1 = (valid &&  g) ? n_data : 0;
    n_checks++;
    if ((rd_cnt[0] - r0) != exp0 || (rd_cnt[1] - r1) != exp1) begin
      $display("FAIL %s read_count: got ch0=%0d ch1=%0d expected ch0=%0d ch1=%0d",
               tag, rd_cnt[0] - r0, rd_cnt[1] - r1, exp0, exp1);
      n_fail++;
    end
  endtask

  task automatic test_reset_state();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (cpu_rd_data !== 128'd0 || ch0_rd_en !== 1'b0 || ch1_rd_en !== 1'b0 ||
        pkt_ch !== 1'b0 || pkt_active !== 1'b0) begin
      $display("FAIL reset_state: got data=%h rd_en=%b%b ch=%b active=%b expected all zero",
               cpu_rd_data, ch1_rd_en, ch0_rd_en, pkt_ch, pkt_active);
      n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    ch0_level = 10'd0;
    ch1_level = 10'd0;
    send_packet(0, 1'b0, LB, "idle");
  endtask

  task automatic test_single_ch0();
    ch0_level = 10'd200;
    ch1_level = 10'd0;
    send_packet(0, 1'b0, LB, "ch0_first");
    send_packet(0, 1'b0, LB, "ch0_second");
  endtask

  task automatic test_round_robin();
    ch0_level = 10'd300;
    ch1_level = 10'd300;
    for (int p = 0; p < 4; p++) send_packet(0, 1'b0, LB, "round_robin");
  endtask

  task automatic test_frame_start();
    ch0_level = 10'd0;
    ch1_level = 10'd300;
    @(negedge clk);
    ch1_fs = 1'b1;
    @(negedge clk);
    ch1_fs = 1'b0;
    pend_m[1] = 1'b1;
    send_packet(0, 1'b0, LB, "fs_sync");
    send_packet(0, 1'b0, LB, "fs_after");
    send_packet(0, 1'b1, LB, "fs_same_cycle");
    send_packet(0, 1'b0, LB, "fs_set_wins");
  endtask

  task automatic test_gaps();
    ch0_level = 10'd300;
    ch1_level = 10'd0;
    send_packet(50, 1'b0, LB, "gaps");
  endtask

  task automatic test_reset();
    ch0_level = 10'd300;
    ch1_level = 10'd0;
    send_packet(0, 1'b0, 80, "pre_reset");
    @(negedge clk);
    rst_n     = 1'b0;
    cpu_rd_en = 1'b1;
    #1;
    n_checks++;
    if (cpu_rd_data !== 128'd0 || ch0_rd_en !== 1'b0 || ch1_rd_en !== 1'b0 ||
        pkt_ch !== 1'b0 || pkt_active !== 1'b0) begin
      $display("FAIL mid_reset: got data=%h rd_en=%b%b ch=%b active=%b expected all zero",
               cpu_rd_data, ch1_rd_en, ch0_rd_en, pkt_ch, pkt_active);
      n_fail++;
    end
    @(negedge clk);
    cpu_rd_en = 1'b0;
    rst_n     = 1'b1;
    model_reset();
    ch1_level = 10'd300;
    send_packet(0, 1'b0, LB, "post_reset");
  endtask

  initial begin
    test_reset_state();
    test_idle();
    test_single_ch0();
    test_round_robin();
    test_frame_start();
    test_gaps();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
